requant_pipe: RTL and testbench



---
 rtl/requant_pkg.sv | 27 ++
 rtl/requant_lane.sv | 73 +++++++
 rtl/requant_pipe.sv | 133 +++++++++++++
 tb/tb_requant_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// Shared types and helpers for the requantisation pipeline: cfg record,
// overflow policy and signed output range bounds.
package requant_pkg;

  localparam int unsigned CFG_MULT_W  = 8;
  localparam int unsigned CFG_SHIFT_W = 5;

  typedef enum logic {
    POL_ZERO = 1'b0,
    POL_SAT  = 1'b1
  } pol_e;

  typedef struct packed {
    logic [CFG_MULT_W-1:0]  mult;
    logic [CFG_SHIFT_W-1:0] shift;
    pol_e                   sat;
  } cfg_t;

  function automatic int qmax(input int unsigned w);
    return (1 <<< (w - 1)) - 1;
  endfunction

  function automatic int qmin(input int unsigned w);
    return -(1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantiser: S1 multiply, S2 rounding shift, S3 zero-point
// add, range check and clip. Stage loads are driven by requant_pipe.
module requant_lane
  import requant_pkg::*;
#(
  parameter int unsigned IN_W    = 18,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned MULT_W  = 8,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld1_i,
  input  logic                      ld2_i,
  input  logic                      ld3_i,
  input  logic signed [IN_W-1:0]    in_lane_i,
  input  logic        [MULT_W-1:0]  mult_i,
  input  logic        [SHIFT_W-1:0] shift_s1_i,
  input  pol_e                      pol_s2_i,
  input  logic signed [OUT_W-1:0]   zp_s2_i,
  output logic        [OUT_W-1:0]   out_o,
  output logic                      ovf_o
);

  localparam int unsigned PW = IN_W + MULT_W + 1;
  localparam int unsigned RW = PW + 1;
  localparam int unsigned VW = RW + 1;

  logic signed [PW-1:0] prod_d, prod_q;
  logic signed [RW-1:0] rnd, sum, shr_d, shr_q;
  logic signed [VW-1:0] val;
  logic                 ovf_hi, ovf_lo;
  logic [OUT_W-1:0]     out_d, out_q;
  logic                 ovf_d, ovf_q;

  always_comb begin
    prod_d = PW'(in_lane_i) * PW'($signed({1'b0, mult_i}));

    // Adding half an LSB before the arithmetic shift rounds half toward +inf.
    rnd = '0;
    if (shift_s1_i != '0) rnd = RW'(1) << (shift_s1_i - SHIFT_W'(1));
    sum   = RW'(prod_q) + rnd;
    shr_d = sum >>> shift_s1_i;

    val    = VW'(shr_q) + VW'(zp_s2_i);
    ovf_hi = val > VW'(qmax(OUT_W));
    ovf_lo = val < VW'(qmin(OUT_W));
    ovf_d  = ovf_hi | ovf_lo;
    out_d  = val[OUT_W-1:0];
    if (ovf_hi) out_d = (pol_s2_i == POL_SAT) ? OUT_W'(qmax(OUT_W)) : '0;
    else if (ovf_lo) out_d = (pol_s2_i == POL_SAT) ? OUT_W'(qmin(OUT_W)) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      shr_q  <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (ld1_i) prod_q <= prod_d;
      if (ld2_i) shr_q  <= shr_d;
      if (ld3_i) begin
        out_q <= out_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_o = out_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/requant_pipe.sv
// Three-stage valid/ready requantiser over NUM_CH lanes with overflow counter.
// Optional zero-point offset enabled by `define REQUANT_ZERO_POINT_EN.
module requant_pipe
  import requant_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned IN_W    = 18,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned MULT_W  = CFG_MULT_W,
  parameter int unsigned SHIFT_W = CFG_SHIFT_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [MULT_W-1:0]       cfg_mult,
  input  logic [SHIFT_W-1:0]      cfg_shift,
  input  logic                    cfg_sat,
`ifdef REQUANT_ZERO_POINT_EN
  input  logic signed [OUT_W-1:0] cfg_zp,
`endif
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [NUM_CH-1:0]       out_ovf,
  output logic [CNT_W-1:0]        ovf_cnt,
  input  logic                    cnt_clr
);

  cfg_t                     cfg_q;
  logic                     v1_q, v2_q, v3_q;
  logic                     en1, en2, en3, ld1, ld2, ld3;
  logic [SHIFT_W-1:0]       shift1_q;
  pol_e                     pol1_q, pol2_q;
  logic signed [OUT_W-1:0]  zp_cur, zp1_q, zp2_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W:0]           cnt_sum;

  // Each stage may load when it is empty or the stage after it moves, so
  // bubbles collapse and in_ready drops only once all three slots are full.
  assign en3      = out_ready || !v3_q;
  assign en2      = en3 || !v2_q;
  assign en1      = en2 || !v1_q;
  assign in_ready = en1;
  assign ld1      = in_valid && en1;
  assign ld2      = v1_q && en2;
  assign ld3      = v2_q && en3;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q    <= '{mult: CFG_MULT_W'(1), shift: '0, sat: POL_ZERO};
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      shift1_q <= '0;
      pol1_q   <= POL_ZERO;
      pol2_q   <= POL_ZERO;
      zp1_q    <= '0;
      zp2_q    <= '0;
    end else begin
      if (cfg_we) begin
        cfg_q.mult  <= CFG_MULT_W'(cfg_mult);
        cfg_q.shift <= CFG_SHIFT_W'(cfg_shift);
        cfg_q.sat   <= pol_e'(cfg_sat);
      end
      if (en1) v1_q <= in_valid;
      if (en2) v2_q <= v1_q;
      if (en3) v3_q <= v2_q;
      if (ld1) begin
        shift1_q <= SHIFT_W'(cfg_q.shift);
        pol1_q   <= cfg_q.sat;
        zp1_q    <= zp_cur;
      end
      if (ld2) begin
        pol2_q <= pol1_q;
        zp2_q  <= zp1_q;
      end
    end
  end

`ifdef REQUANT_ZERO_POINT_EN
  logic signed [OUT_W-1:0] zp_q;
  always_ff @(posedge clk) begin
    if (rst) zp_q <= '0;
    else if (cfg_we) zp_q <= cfg_zp;
  end
  assign zp_cur = zp_q;
`else
  assign zp_cur = '0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    requant_lane #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .MULT_W (MULT_W),
      .SHIFT_W(SHIFT_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .ld1_i     (ld1),
      .ld2_i     (ld2),
      .ld3_i     (ld3),
      .in_lane_i (in_data[g*IN_W +: IN_W]),
      .mult_i    (MULT_W'(cfg_q.mult)),
      .shift_s1_i(shift1_q),
      .pol_s2_i  (pol2_q),
      .zp_s2_i   (zp2_q),
      .out_o     (out_data[g*OUT_W +: OUT_W]),
      .ovf_o     (out_ovf[g])
    );
  end

  always_comb begin
    cnt_sum = {1'b0, cnt_q};
    for (int unsigned i = 0; i < NUM_CH; i++) cnt_sum = cnt_sum + (CNT_W + 1)'(out_ovf[i]);
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (out_valid && out_ready) cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_valid = v3_q;
  assign ovf_cnt   = cnt_q;

endmodule

// File: tb/tb_requant_pipe.sv
// Directed bench for requant_pipe with a queue scoreboard fed at input accept
// and drained by an output monitor.
module tb_requant_pipe;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned IN_W   = 18;
  localparam int unsigned OUT_W  = 8;
  localparam int unsigned CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst, cfg_we, cfg_sat, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [7:0]              cfg_mult;
  logic [4:0]              cfg_shift;
  logic [NUM_CH*IN_W-1:0]  in_data;
  logic [NUM_CH*OUT_W-1:0] out_data;
  logic [NUM_CH-1:0]       out_ovf;
  logic [CNT_W-1:0]        ovf_cnt;

  requant_pipe #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .MULT_W(8), .SHIFT_W(5), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
    .cfg_sat(cfg_sat), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  ov;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  int          m_mult = 1, m_shift = 0;
  bit          m_sat = 1'b0;
  logic [31:0] last_out = '0;
  logic [31:0] prev_d;
  logic [3:0]  prev_ov;
  bit          prev_stall = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] pack(input int a, input int b, input int c, input int d);
    return {18'(d), 18'(c), 18'(b), 18'(a)};
  endfunction

  function automatic exp_t model(input logic [71:0] din);
    exp_t   e;
    longint x, p;
    e.d  = '0;
    e.ov = '0;
    for (int i = 0; i < 4; i++) begin
      x = longint'($signed(din[i*18 +: 18]));
      p = x * m_mult;
      if (m_shift > 0) p = p + (longint'(1) << (m_shift - 1));
      p = p >>> m_shift;
      if (p > 127) begin
        e.ov[i] = 1'b1;
        e.d[i*8 +: 8] = m_sat ? 8'h7f : 8'h00;
      end else if (p < -128) begin
        e.ov[i] = 1'b1;
        e.d[i*8 +: 8] = m_sat ? 8'h80 : 8'h00;
      end else begin
        e.d[i*8 +: 8] = p[7:0];
      end
    end
    return e;
  endfunction

  // Output side of the scoreboard, plus hold checks while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_d);
        check("hold_ovf", out_ovf, prev_ov);
      end
      if (out_valid && out_ready) begin
        n_chk++;
        assert (sb.size() != 0)
        else begin
          n_fail++;
          $error("FAIL unexpected_beat: observed data %0h with empty scoreboard, expected no beat", out_data);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", out_data, e.d);
          check("out_ovf", out_ovf, e.ov);
          last_out = out_data;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_ov    = out_ovf;
    end
  end

  task automatic send(input logic [71:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", in_ready, 1);
    if (in_ready) sb.push_back(model(d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic set_cfg(input int m, input int s, input bit sat);
    cfg_we    = 1'b1;
    cfg_mult  = 8'(m);
    cfg_shift = 5'(s);
    cfg_sat   = sat;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
    m_mult  = m;
    m_shift = s;
    m_sat   = sat;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, cyc;
    rst = 1'b1; cfg_we = 1'b0; cfg_mult = '0; cfg_shift = '0; cfg_sat = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Default config: identity with zero-on-overflow, 3-cycle latency.
    send(pack(127, -128, 128, -129));
    @(negedge clk); check("lat_c1", out_valid, 0);
    @(negedge clk); check("lat_c2", out_valid, 0);
    @(negedge clk); check("lat_c3", out_valid, 1);
    check("t1_data", out_data, 32'h0000_807f);
    check("t1_ovf", out_ovf, 4'b1100);
    drain();
    check("t1_cnt", ovf_cnt, 2);

    set_cfg(1, 0, 1'b1);
    send(pack(127, -128, 128, -129));
    drain();
    check("t2_data", last_out, 32'h807f_807f);
    check("t2_cnt", ovf_cnt, 4);

    set_cfg(3, 2, 1'b0);
    send(pack(5, -5, 2, -2));
    drain();
    check("t3_data", last_out, 32'hff02_fc04);

    // Cfg write on the accept edge must apply only to the following beat.
    cfg_we = 1'b1; cfg_mult = 8'd2; cfg_shift = 5'd0; cfg_sat = 1'b1;
    send(pack(5, -5, 2, -2));
    cfg_we = 1'b0; m_mult = 2; m_shift = 0; m_sat = 1'b1;
    send(pack(100, -100, 1, -1));
    drain();
    check("t4_data", last_out, 32'hfe02_807f);
    check("t4_cnt", ovf_cnt, 6);

    set_cfg(3, 2, 1'b0);
    k = 0;
    cyc = 0;
    while (k < 6 && cyc < 100) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = 1'b1;
      in_data   = pack(10 * k + 1, -10 * k - 3, 7 * k, -k);
      @(negedge clk);
      if (cyc == 6) check("stall_in_ready", in_ready, 0);
      if (in_ready) begin
        sb.push_back(model(in_data));
        k++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_beats", k, 6);
    drain();
    check("stream_cnt", ovf_cnt, 6);

    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("clr_cnt", ovf_cnt, 0);

    set_cfg(1, 0, 1'b1);
    for (int i = 0; i < 16383; i++) send(pack(200, -200, 300, -300));
    send(pack(200, -200, 1, 1));
    drain();
    check("cnt_65534", ovf_cnt, 65534);
    send(pack(200, -200, 300, -300));
    drain();
    check("cnt_sat", ovf_cnt, 65535);
    cnt_clr = 1'b1;
    send(pack(200, -200, 300, -300));
    drain();
    cnt_clr = 1'b0;
    check("cnt_clr_wins", ovf_cnt, 0);

    // Reset with three beats in flight.
    set_cfg(5, 1, 1'b1);
    out_ready = 1'b0;
    send(pack(1, 2, 3, 4));
    send(pack(5, 6, 7, 8));
    send(pack(9, 10, 11, 12));
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_mult = 1; m_shift = 0; m_sat = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_ovf", out_ovf, 0);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_stale", out_valid, 0);
    send(pack(127, -128, 128, -129));
    drain();
    check("midrst_cfg_default", last_out, 32'h0000_807f);
    check("midrst_cnt", ovf_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
